// File: rtl/alu_pkg.sv
// alu_pkg: unit selects, op codes and FSM states shared by the pipelined ALU
package alu_pkg;
  localparam logic [1:0] UNIT_ARITH = 2'b00;
  localparam logic [1:0] UNIT_LOGIC = 2'b01;
  localparam logic [1:0] UNIT_SHIFT = 2'b10;
  localparam logic [1:0] UNIT_SETC  = 2'b11;
  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_ADDU = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_SUBU = 3'd3;
  localparam logic [2:0] OP_INC  = 3'd4;
  localparam logic [2:0] OP_DEC  = 3'd5;
  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NOT  = 3'd3;
  localparam logic [2:0] OP_NAND = 3'd4;
  localparam logic [2:0] OP_NOR  = 3'd5;
  localparam logic [2:0] OP_XNOR = 3'd6;
  localparam logic [2:0] OP_SLL  = 3'd0;
  localparam logic [2:0] OP_SRL  = 3'd1;
  localparam logic [2:0] OP_SLA  = 3'd2;
  localparam logic [2:0] OP_SRA  = 3'd3;
  localparam logic [2:0] OP_ROL  = 3'd4;
  localparam logic [2:0] OP_ROR  = 3'd5;
  localparam logic [2:0] OP_LE   = 3'd0;
  localparam logic [2:0] OP_LT   = 3'd1;
  localparam logic [2:0] OP_GE   = 3'd2;
  localparam logic [2:0] OP_GT   = 3'd3;
  localparam logic [2:0] OP_EQ   = 3'd4;
  localparam logic [2:0] OP_NE   = 3'd5;
  typedef enum logic {IDLE, SHIFT} alu_state_t;
endpackage

// File: rtl/alu_pipe_if.sv
// alu_pipe_if: operand/result handshake bundle between operand fetch and writeback
interface alu_pipe_if #(parameter int WIDTH = 16);
  logic             in_valid, in_ready;
  logic [WIDTH-1:0] a, b;
  logic [4:0]       alu_code;
  logic             out_valid, out_ready;
  logic [WIDTH-1:0] c;
  logic             overflow, zero, neg, ovf_sticky, clr_sticky;
  modport master (output in_valid, a, b, alu_code, out_ready, clr_sticky,
                  input  in_ready, out_valid, c, overflow, zero, neg, ovf_sticky);
  modport slave  (input  in_valid, a, b, alu_code, out_ready, clr_sticky,
                  output in_ready, out_valid, c, overflow, zero, neg, ovf_sticky);
endinterface

// File: rtl/alu_comb.sv
// alu_comb: single-cycle arith/logic/set-cond result and overflow; other units pass a
module alu_comb import alu_pkg::*; #(parameter int WIDTH = 16) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [4:0]       code_i,
  output logic [WIDTH-1:0] res_o,
  output logic             ovf_o
);
  logic [WIDTH:0]   sum, dif;
  logic [WIDTH-1:0] inc, dec;
  logic             lt, eq, setc;
  logic [2:0]       op;
  assign op  = code_i[2:0];
  assign sum = {1'b0, a_i} + {1'b0, b_i};
  assign dif = {1'b0, a_i} - {1'b0, b_i};
  assign inc = a_i + WIDTH'(1);
  assign dec = a_i - WIDTH'(1);
  assign lt  = $signed(a_i) < $signed(b_i);
  assign eq  = a_i == b_i;
  // signed compare outcome for the set-cond unit
  always_comb begin
    setc = 1'b0;
    case (op)
      OP_LE:   setc = lt | eq;
      OP_LT:   setc = lt;
      OP_GE:   setc = !lt;
      OP_GT:   setc = !(lt | eq);
      OP_EQ:   setc = eq;
      OP_NE:   setc = !eq;
      default: setc = 1'b0;
    endcase
  end
  // unit/op result select; signed ops flag two's-complement overflow, unsigned ops carry/borrow
  always_comb begin
    res_o = a_i;
    ovf_o = 1'b0;
    case (code_i[4:3])
      UNIT_ARITH:
        case (op)
          OP_ADD:  begin res_o = sum[WIDTH-1:0]; ovf_o = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]); end
          OP_ADDU: begin res_o = sum[WIDTH-1:0]; ovf_o = sum[WIDTH]; end
          OP_SUB:  begin res_o = dif[WIDTH-1:0]; ovf_o = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (dif[WIDTH-1] != a_i[WIDTH-1]); end
          OP_SUBU: begin res_o = dif[WIDTH-1:0]; ovf_o = dif[WIDTH]; end
          OP_INC:  begin res_o = inc; ovf_o = inc[WIDTH-1] & ~a_i[WIDTH-1]; end
          OP_DEC:  begin res_o = dec; ovf_o = ~dec[WIDTH-1] & a_i[WIDTH-1]; end
          default: res_o = a_i;
        endcase
      UNIT_LOGIC:
        case (op)
          OP_AND:  res_o = a_i & b_i;
          OP_OR:   res_o = a_i | b_i;
          OP_XOR:  res_o = a_i ^ b_i;
          OP_NOT:  res_o = ~a_i;
          OP_NAND: res_o = ~(a_i & b_i);
          OP_NOR:  res_o = ~(a_i | b_i);
          OP_XNOR: res_o = ~(a_i ^ b_i);
          default: res_o = a_i;
        endcase
      UNIT_SETC: res_o = {{(WIDTH-1){1'b0}}, setc};
      default:   res_o = a_i;
    endcase
  end
endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked ALU with registered result, iterative 1-bit/cycle shifter and sticky overflow
module alu_pipe import alu_pkg::*; #(parameter int WIDTH = 16) (
  input logic clk,
  input logic rst,
  alu_pipe_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);
  alu_state_t       state_q;
  logic [WIDTH-1:0] c_q, work_q, comb_res, step_val, c_d;
  logic [SHW-1:0]   cnt_q, n;
  logic [2:0]       sop_q, op;
  logic             sovf_q, out_valid_q, ovf_q, zero_q, neg_q, sticky_q;
  logic             comb_ovf, step_ovf, ovf_d, accept, start_shift, last, load;
  alu_comb #(.WIDTH(WIDTH)) u_comb (
    .a_i(bus.a), .b_i(bus.b), .code_i(bus.alu_code), .res_o(comb_res), .ovf_o(comb_ovf)
  );
  assign n             = bus.b[SHW-1:0];
  assign op            = bus.alu_code[2:0];
  assign bus.in_ready  = state_q == IDLE && (!out_valid_q || bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;
  assign start_shift   = accept && bus.alu_code[4:3] == UNIT_SHIFT && op < 3'd6 && n != '0;
  assign last          = state_q == SHIFT && cnt_q == SHW'(1);
  assign load          = (accept && !start_shift) || last;
  assign c_d           = last ? step_val : comb_res;
  assign ovf_d         = last ? (sovf_q | step_ovf) : comb_ovf;
  assign bus.out_valid  = out_valid_q;
  assign bus.c          = c_q;
  assign bus.overflow   = ovf_q;
  assign bus.zero       = zero_q;
  assign bus.neg        = neg_q;
  assign bus.ovf_sticky = sticky_q;
  // one-bit step of the working register; SLA flags a sign change on this step
  always_comb begin
    step_ovf = sop_q == OP_SLA && (work_q[WIDTH-1] ^ work_q[WIDTH-2]);
    step_val = sop_q == OP_SLL || sop_q == OP_SLA ? {work_q[WIDTH-2:0], 1'b0} :
               sop_q == OP_SRL ? {1'b0, work_q[WIDTH-1:1]} :
               sop_q == OP_SRA ? {work_q[WIDTH-1], work_q[WIDTH-1:1]} :
               sop_q == OP_ROL ? {work_q[WIDTH-2:0], work_q[WIDTH-1]} :
               sop_q == OP_ROR ? {work_q[0], work_q[WIDTH-1:1]} : work_q;
  end
  // FSM, shifter state, output register and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      c_q         <= '0;
      work_q      <= '0;
      cnt_q       <= '0;
      sop_q       <= '0;
      sovf_q      <= 1'b0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      if (load) begin
        c_q         <= c_d;
        ovf_q       <= ovf_d;
        zero_q      <= c_d == '0;
        neg_q       <= c_d[WIDTH-1];
        out_valid_q <= 1'b1;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      sticky_q <= (load && ovf_d) || (sticky_q && !bus.clr_sticky);
      case (state_q)
        IDLE:
          if (start_shift) begin
            state_q <= SHIFT;
            work_q  <= bus.a;
            cnt_q   <= n;
            sop_q   <= op;
            sovf_q  <= 1'b0;
          end
        SHIFT: begin
          work_q  <= step_val;
          cnt_q   <= cnt_q - SHW'(1);
          sovf_q  <= sovf_q | step_ovf;
          state_q <= last ? IDLE : SHIFT;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
